// File: rtl/inference_sequencer_if.sv
// AXI4-Lite bundle between the inference sequencer and the chip-control slave.
interface inference_sequencer_if;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport Slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/inference_sequencer.sv
// Drives one inference on the chip-control slave: writes four observations and the mode,
// reads the result register once (log) or N_DRAWS times (stochastic), accumulates and reports argmax.
module inference_sequencer #(
    parameter int unsigned N_DRAWS   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   obs_valid,
    output logic                   obs_ready,
    input  logic [35:0]            obs_data,
    input  logic                   obs_log,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [1:0]             res_class,
    output logic [63:0]            res_score,
    output logic                   res_err,
    inference_sequencer_if.Master  axi_port
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_OBS  = 3'd1;
    localparam logic [2:0] WR_MODE = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;
    localparam logic [2:0] ACC     = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic [35:0]       obs_q, obs_d;
    logic              log_q, log_d;
    logic [3:0][15:0]  acc_q, acc_d;
    logic [7:0]        draws_q, draws_d;
    logic [2:0]        idx_q, idx_d;
    logic              b_phase_q, b_phase_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              b_ready_q, b_ready_d;
    logic              ar_valid_q, ar_valid_d;
    logic              r_ready_q, r_ready_d;
    logic              res_err_q, res_err_d;
    logic              abort;
    logic              timed_out;
    logic [31:0]       w_data_c;

    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        obs_d      = obs_q;
        log_d      = log_q;
        acc_d      = acc_q;
        draws_d    = draws_q;
        idx_d      = idx_q;
        b_phase_d  = b_phase_q;
        timer_d    = timer_q;
        rdata_d    = rdata_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        res_err_d  = res_err_q;
        abort      = 1'b0;

        case (state_q)
            IDLE: begin
                if (obs_valid) begin
                    state_d    = WR_OBS;
                    obs_d      = obs_data;
                    log_d      = obs_log;
                    acc_d      = '0;
                    draws_d    = '0;
                    idx_d      = '0;
                    b_phase_d  = 1'b0;
                    timer_d    = '0;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    b_ready_d  = 1'b1;
                    res_err_d  = 1'b0;
                end
            end
            // Each write is an AW/W phase followed by a B phase; b_ready stays high across both.
            WR_OBS, WR_MODE: begin
                if (!b_phase_q) begin
                    if (axi_port.aw_ready && axi_port.w_ready) begin
                        aw_valid_d = 1'b0;
                        w_valid_d  = 1'b0;
                        b_phase_d  = 1'b1;
                        timer_d    = '0;
                    end else if (timed_out) begin
                        abort = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end else if (axi_port.b_valid) begin
                    if (axi_port.b_resp != 2'b00) begin
                        abort = 1'b1;
                    end else begin
                        timer_d   = '0;
                        b_phase_d = 1'b0;
                        if (idx_q == 3'd4) begin
                            b_ready_d  = 1'b0;
                            ar_valid_d = 1'b1;
                            state_d    = RD_REQ;
                        end else begin
                            idx_d      = idx_q + 3'd1;
                            aw_valid_d = 1'b1;
                            w_valid_d  = 1'b1;
                            state_d    = (idx_q == 3'd3) ? WR_MODE : WR_OBS;
                        end
                    end
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RD_REQ: begin
                if (axi_port.ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    timer_d    = '0;
                    state_d    = RD_RESP;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RD_RESP: begin
                if (axi_port.r_valid) begin
                    r_ready_d = 1'b0;
                    if (axi_port.r_resp != 2'b00) begin
                        abort = 1'b1;
                    end else begin
                        rdata_d = axi_port.r_data;
                        state_d = ACC;
                    end
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ACC: begin
                for (int k = 0; k < 4; k++) begin
                    acc_d[k] = acc_q[k] + {8'h00, rdata_q[8*k +: 8]};
                end
                draws_d = draws_q + 8'd1;
                if ((({1'b0, draws_q} + 9'd1) < 9'(N_DRAWS)) && !log_q) begin
                    ar_valid_d = 1'b1;
                    timer_d    = '0;
                    state_d    = RD_REQ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A bad response or a stalled handshake drops every request and reports what was accumulated.
        if (abort) begin
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
            b_ready_d  = 1'b0;
            ar_valid_d = 1'b0;
            r_ready_d  = 1'b0;
            timer_d    = '0;
            res_err_d  = 1'b1;
            state_d    = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            obs_q      <= '0;
            log_q      <= 1'b0;
            acc_q      <= '0;
            draws_q    <= '0;
            idx_q      <= '0;
            b_phase_q  <= 1'b0;
            timer_q    <= '0;
            rdata_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            obs_q      <= obs_d;
            log_q      <= log_d;
            acc_q      <= acc_d;
            draws_q    <= draws_d;
            idx_q      <= idx_d;
            b_phase_q  <= b_phase_d;
            timer_q    <= timer_d;
            rdata_q    <= rdata_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            res_err_q  <= res_err_d;
        end
    end

    // Write index 4 is the mode register, which sits right after the four observation registers.
    always_comb begin
        w_data_c = {31'b0, log_q};
        if (idx_q != 3'd4) begin
            w_data_c = {23'b0, obs_q[9*idx_q[1:0] +: 9]};
        end
    end

    always_comb begin
        res_class = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (acc_q[k] > acc_q[res_class]) begin
                res_class = 2'(k);
            end
        end
    end

    assign obs_ready = (state_q == IDLE) && !rst;
    assign res_valid = (state_q == DONE);
    assign res_err   = res_err_q;
    assign res_score = acc_q;

    assign axi_port.aw_addr  = BASE_ADDR + 32'h0000_200C + {27'b0, idx_q, 2'b00};
    assign axi_port.aw_prot  = 3'b000;
    assign axi_port.aw_valid = aw_valid_q;
    assign axi_port.w_data   = w_data_c;
    assign axi_port.w_strb   = 4'hF;
    assign axi_port.w_valid  = w_valid_q;
    assign axi_port.b_ready  = b_ready_q;
    assign axi_port.ar_addr  = BASE_ADDR + 32'h0000_2000;
    assign axi_port.ar_prot  = 3'b000;
    assign axi_port.ar_valid = ar_valid_q;
    assign axi_port.r_ready  = r_ready_q;
endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: an AXI-Lite slave model feeds read data, a reference model
// predicts each inference result into a scoreboard queue that is drained on every result handshake.
module tb_inference_sequencer;
    localparam int          N_DRAWS   = 16;
    localparam logic [31:0] BASE_ADDR = 32'h4000_0000;
    localparam int          TIMEOUT   = 4096;

    typedef struct {
        logic [1:0]  cls;
        logic [63:0] score;
        logic        err;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        obs_valid;
    logic        obs_ready;
    logic [35:0] obs_data;
    logic        obs_log;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_class;
    logic [63:0] res_score;
    logic        res_err;

    inference_sequencer_if axi ();

    inference_sequencer #(
        .N_DRAWS   (N_DRAWS),
        .BASE_ADDR (BASE_ADDR),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .obs_valid (obs_valid),
        .obs_ready (obs_ready),
        .obs_data  (obs_data),
        .obs_log   (obs_log),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_score (res_score),
        .res_err   (res_err),
        .axi_port  (axi)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    res_t        exp_q[$];
    wr_t         wr_exp[$];
    logic [33:0] rd_q[$];
    int          aw_delay    = 0;
    int          r_delay     = 0;
    int          wr_seen     = 0;
    int          rd_seen     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic void pushWrites(input logic [35:0] obs, input logic lg);
        wr_t w;
        for (int k = 0; k < 4; k++) begin
            w.addr = BASE_ADDR + 32'h200C + 32'(4 * k);
            w.data = {23'b0, obs[9*k +: 9]};
            wr_exp.push_back(w);
        end
        w.addr = BASE_ADDR + 32'h201C;
        w.data = {31'b0, lg};
        wr_exp.push_back(w);
    endfunction

    // AXI-Lite slave: levels change on the falling edge, so a handshake happens at a rising edge
    // exactly when both sides were high at the preceding falling edge.
    initial begin : slave
        bit          aw_fire, b_fire, ar_fire, r_fire, aw_wait, ar_wait, r_pending;
        int          aw_cnt, r_cnt;
        logic [31:0] p_aw_addr, p_w_data, p_ar_addr;
        logic [33:0] ent;
        wr_t         w;
        aw_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_wait = 0; ar_wait = 0; r_pending = 0; aw_cnt = 0; r_cnt = 0;
        p_aw_addr = '0; p_w_data = '0; p_ar_addr = '0;
        axi.aw_ready = 0; axi.w_ready = 0; axi.b_valid = 0; axi.b_resp = 2'b00;
        axi.ar_ready = 0; axi.r_valid = 0; axi.r_resp = 2'b00; axi.r_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.aw_ready = 0; axi.w_ready = 0; axi.b_valid = 0;
                axi.ar_ready = 0; axi.r_valid = 0;
                aw_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_wait = 0; ar_wait = 0; r_pending = 0; aw_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_fire) begin
                    axi.aw_ready = 0; axi.w_ready = 0; aw_cnt = 0;
                    axi.b_valid = 1; axi.b_resp = 2'b00;
                end
                if (b_fire) axi.b_valid = 0;
                if (ar_fire) begin
                    axi.ar_ready = 0; r_pending = 1; r_cnt = 0;
                end
                if (r_fire) begin
                    axi.r_valid = 0; r_pending = 0;
                end

                if (aw_wait && !res_valid) begin
                    checkOutput("aw_hold", {axi.aw_valid, axi.w_valid, axi.aw_addr}, {2'b11, p_aw_addr});
                    checkOutput("w_hold", axi.w_data, p_w_data);
                end
                if (ar_wait && !res_valid) begin
                    checkOutput("ar_hold", {axi.ar_valid, axi.ar_addr}, {1'b1, p_ar_addr});
                end

                if (axi.aw_valid && axi.w_valid) begin
                    if (!axi.aw_ready) begin
                        aw_cnt++;
                        if (aw_cnt > aw_delay) begin
                            axi.aw_ready = 1; axi.w_ready = 1;
                        end
                    end
                end else begin
                    aw_cnt = 0; axi.aw_ready = 0; axi.w_ready = 0;
                end
                axi.ar_ready = axi.ar_valid && !r_pending;
                if (r_pending && !axi.r_valid && axi.r_ready) begin
                    r_cnt++;
                    if (r_cnt > r_delay) begin
                        if (rd_q.size() > 0) begin
                            ent = rd_q.pop_front();
                        end else begin
                            ent = '0;
                            checkOutput("rd_extra", 64'd1, 64'd0);
                        end
                        axi.r_data  = ent[31:0];
                        axi.r_resp  = ent[33:32];
                        axi.r_valid = 1;
                    end
                end

                aw_fire = axi.aw_valid && axi.w_valid && axi.aw_ready && axi.w_ready;
                b_fire  = axi.b_valid && axi.b_ready;
                ar_fire = axi.ar_valid && axi.ar_ready;
                r_fire  = axi.r_valid && axi.r_ready;

                if (aw_fire) begin
                    wr_seen++;
                    if (wr_exp.size() == 0) begin
                        checkOutput("wr_extra", 64'd1, 64'd0);
                    end else begin
                        w = wr_exp.pop_front();
                        checkOutput("wr_addr", axi.aw_addr, w.addr);
                        checkOutput("wr_data", axi.w_data, w.data);
                    end
                    checkOutput("wr_strb_prot", {axi.w_strb, axi.aw_prot}, {4'hF, 3'b000});
                    checkOutput("wr_excl", {axi.ar_valid, axi.r_ready}, 2'b00);
                end
                if (ar_fire) begin
                    rd_seen++;
                    checkOutput("rd_addr", {axi.ar_prot, axi.ar_addr}, {3'b000, BASE_ADDR + 32'h2000});
                    checkOutput("rd_excl", {axi.aw_valid, axi.w_valid, axi.b_ready}, 3'b000);
                end

                aw_wait   = axi.aw_valid && !aw_fire;
                p_aw_addr = axi.aw_addr;
                p_w_data  = axi.w_data;
                ar_wait   = axi.ar_valid && !ar_fire;
                p_ar_addr = axi.ar_addr;
            end
        end
    end

    // Result monitor: pops the scoreboard whenever a result is about to be handed over.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("res_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("res_class", res_class, e.cls);
                    checkOutput("res_score", res_score, e.score);
                    checkOutput("res_err", res_err, e.err);
                end
            end
        end
    end

    task automatic driveObs(input logic [35:0] obs, input logic lg);
        int n;
        @(negedge clk);
        obs_valid = 1'b1;
        obs_data  = obs;
        obs_log   = lg;
        n = 0;
        while (!obs_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!obs_ready) begin
            checkOutput("obs_ready_wait", 64'd0, 64'd1);
            obs_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 obs_valid = 1'b0;
            @(negedge clk);
            checkOutput("obs_ready_busy", obs_ready, 1'b0);
        end
    endtask

    task automatic applyStimulus(input logic [35:0] obs, input logic lg, input int awd, input int rdd);
        logic [15:0] s[4];
        res_t        e;
        int          limit, nwr, nrd, n;
        logic [2:0]  snap;
        logic [63:0] snap_score;
        aw_delay = awd;
        r_delay  = rdd;
        wr_seen  = 0;
        rd_seen  = 0;
        wr_exp.delete();
        for (int k = 0; k < 4; k++) s[k] = '0;
        e.err = 1'b0;
        nrd   = 0;
        limit = lg ? 1 : N_DRAWS;
        if (awd >= TIMEOUT) begin
            e.err = 1'b1;
            nwr   = 0;
        end else begin
            nwr = 5;
            for (int i = 0; i < limit && i < rd_q.size(); i++) begin
                nrd++;
                if (rd_q[i][33:32] != 2'b00) begin
                    e.err = 1'b1;
                    break;
                end
                for (int k = 0; k < 4; k++) s[k] = s[k] + {8'h00, rd_q[i][8*k +: 8]};
            end
        end
        e.cls = 2'd0;
        for (int k = 1; k < 4; k++) if (s[k] > s[e.cls]) e.cls = 2'(k);
        e.score = {s[3], s[2], s[1], s[0]};
        exp_q.push_back(e);
        pushWrites(obs, lg);

        driveObs(obs, lg);
        n = 0;
        while (!res_valid && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            checkOutput("res_wait_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end else begin
            snap       = {res_err, res_class};
            snap_score = res_score;
            repeat (3) begin
                @(negedge clk);
                checkOutput("res_hold", {res_valid, res_err, res_class}, {1'b1, snap});
                checkOutput("score_hold", res_score, snap_score);
            end
            @(posedge clk);
            #1 res_ready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1 res_ready = 1'b0;
            @(negedge clk);
            checkOutput("res_drop", {res_valid, obs_ready}, 2'b01);
        end
        checkOutput("n_writes", wr_seen, nwr);
        checkOutput("n_reads", rd_seen, nrd);
        rd_q.delete();
        aw_delay = 0;
        r_delay  = 0;
    endtask

    initial begin
        logic [35:0] ob;
        int          n;
        rst       = 1'b1;
        obs_valid = 1'b0;
        obs_data  = '0;
        obs_log   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs", {obs_ready, res_valid, res_err, axi.aw_valid, axi.w_valid,
                                    axi.b_ready, axi.ar_valid, axi.r_ready}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", {obs_ready, res_valid}, 2'b10);

        $display("[TB] log mode, single read");
        rd_q.push_back({2'b00, 32'h1080_2040});
        applyStimulus({9'h1A3, 9'h0FF, 9'h010, 9'h005}, 1'b1, 0, 0);

        $display("[TB] stochastic, constant draws");
        repeat (N_DRAWS) rd_q.push_back({2'b00, 32'h0102_0304});
        applyStimulus({9'h001, 9'h002, 9'h003, 9'h004}, 1'b0, 0, 0);

        $display("[TB] stochastic, four-way tie");
        repeat (N_DRAWS) rd_q.push_back({2'b00, 32'h0707_0707});
        applyStimulus({9'h1FF, 9'h000, 9'h155, 9'h0AA}, 1'b0, 0, 0);

        $display("[TB] slow slave, random draws");
        repeat (N_DRAWS) rd_q.push_back({2'b00, 32'($urandom)});
        ob = {4'($urandom), 32'($urandom)};
        applyStimulus(ob, 1'b0, 10, 20);

        $display("[TB] error response on second read");
        rd_q.push_back({2'b00, 32'h1122_3344});
        rd_q.push_back({2'b10, 32'hFFFF_FFFF});
        repeat (4) rd_q.push_back({2'b00, 32'h0101_0101});
        applyStimulus({9'h00F, 9'h0F0, 9'h111, 9'h1E1}, 1'b0, 0, 0);

        $display("[TB] write handshake timeout");
        rd_q.push_back({2'b00, 32'h0000_0001});
        applyStimulus({9'h003, 9'h002, 9'h001, 9'h000}, 1'b0, 5000, 0);

        $display("[TB] reset during read response");
        rd_q.push_back({2'b00, 32'hAABB_CCDD});
        r_delay = 20;
        wr_seen = 0;
        wr_exp.delete();
        pushWrites({9'h011, 9'h022, 9'h033, 9'h044}, 1'b1);
        driveObs({9'h011, 9'h022, 9'h033, 9'h044}, 1'b1);
        n = 0;
        while (!axi.r_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rd_resp_reached", axi.r_ready, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_outputs", {obs_ready, res_valid, res_err, axi.aw_valid, axi.w_valid,
                                        axi.b_ready, axi.ar_valid, axi.r_ready}, 8'h00);
        checkOutput("rst_mid_score", res_score, 64'd0);
        checkOutput("rst_mid_writes", wr_seen, 5);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_q.delete();
        r_delay = 0;
        @(negedge clk);
        checkOutput("rst_mid_ready", obs_ready, 1'b1);

        $display("[TB] recovery after reset");
        rd_q.push_back({2'b00, 32'h00FF_0001});
        applyStimulus({9'h100, 9'h080, 9'h040, 9'h020}, 1'b1, 0, 0);
        repeat (N_DRAWS) rd_q.push_back({2'b00, 32'($urandom)});
        applyStimulus({4'($urandom), 32'($urandom)}, 1'b0, 0, 3);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
